// File: rtl/mem_access_unit.sv
// Memory stage: multi-cycle word/half/byte load-store unit with pipeline stall.
// Define MEM_ACCESS_STATS_EN to build the load/store/stall-cycle statistics counters.
module mem_access_unit #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AlignErr,
   output logic [31:0] LoadCount,
   output logic [31:0] StoreCount,
   output logic [31:0] StallCycles
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_mem [DEPTH];

   logic          w_req;
   logic          w_misalign;
   logic          w_access;
   logic [AW-1:0] w_idx;
   logic [4:0]    w_shift;
   logic [31:0]   w_word;
   logic [31:0]   w_lane;
   logic [31:0]   w_rdata;
   logic [31:0]   w_wsh;
   logic [3:0]    w_be;
   logic [31:0]   w_merged;
   logic          w_unused;

   assign w_req      = MemRead | MemWrite;
   assign w_misalign = ((Size == 2'b00 || Size == 2'b11) && Address[1:0] != 2'b00) ||
                       (Size == 2'b01 && Address[0]);
   assign w_access   = (r_state == S_BUSY) && (r_cnt == '0);
   assign w_idx      = Address[AW+1:2];
   assign w_shift    = {Address[1:0], 3'b000};
   assign w_word     = r_mem[w_idx];
   assign w_lane     = w_word >> w_shift;
   assign w_wsh      = WriteData << w_shift;
   assign w_unused   = ^Address[31:AW+2];

   assign Stall = (r_state == S_BUSY) || (r_state == S_IDLE && w_req);

   // Lane extraction and sign/zero extension of the load result
   always_comb begin
      w_rdata = w_word;
      case (Size)
         2'b01:   w_rdata = Unsigned ? {16'h0000, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
         2'b10:   w_rdata = Unsigned ? {24'h000000, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
         default: w_rdata = w_word;
      endcase
   end

   // Byte-enable merge so a partial store preserves the untouched lanes
   always_comb begin
      w_be = 4'b1111;
      case (Size)
         2'b01:   w_be = 4'b0011 << Address[1:0];
         2'b10:   w_be = 4'b0001 << Address[1:0];
         default: w_be = 4'b1111;
      endcase
      w_merged = w_word;
      for (int b = 0; b < 4; b++) begin
         w_merged[8*b +: 8] = w_be[b] ? w_wsh[8*b +: 8] : w_word[8*b +: 8];
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst && w_access && MemWrite) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         ReadData <= '0;
         AlignErr <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_misalign) begin
                     r_state  <= S_DONE;
                     AlignErr <= 1'b1;
                     ReadData <= '0;
                  end else begin
                     r_state <= S_BUSY;
                     r_cnt   <= CW'(LATENCY - 1);
                  end
               end else begin
                  AlignErr <= 1'b0;
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  if (MemWrite) begin
                     if (MemRead) ReadData <= '0;
                  end else begin
                     ReadData <= w_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               AlignErr <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef MEM_ACCESS_STATS_EN
   logic [31:0] r_load_cnt;
   logic [31:0] r_store_cnt;
   logic [31:0] r_stall_cnt;

   // Saturating statistics; an access counts on the edge that enters DONE from BUSY
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_load_cnt  <= '0;
         r_store_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_access && MemRead && !MemWrite && r_load_cnt != 32'hFFFF_FFFF)
            r_load_cnt <= r_load_cnt + 32'd1;
         if (w_access && MemWrite && r_store_cnt != 32'hFFFF_FFFF)
            r_store_cnt <= r_store_cnt + 32'd1;
         if (Stall && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign LoadCount   = r_load_cnt;
   assign StoreCount  = r_store_cnt;
   assign StallCycles = r_stall_cnt;
`else
   assign LoadCount   = '0;
   assign StoreCount  = '0;
   assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned NBYTES  = 4 * DEPTH;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        MemRead, MemWrite, Unsigned;
   logic [1:0]  Size;
   logic [31:0] Address, WriteData;
   logic [31:0] ReadData, LoadCount, StoreCount, StallCycles;
   logic        Stall, AlignErr;

   mem_access_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
      .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .AlignErr(AlignErr), .LoadCount(LoadCount), .StoreCount(StoreCount),
      .StallCycles(StallCycles)
   );

   always #5 Clk = ~Clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [7:0]  mb [NBYTES];
   logic [31:0] exp_rd = '0;
   int unsigned m_loads = 0, m_stores = 0, m_stalls = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      int n = nbytes(sz);
      int base = int'(a % NBYTES) / n * n;
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int n = nbytes(sz);
      int base = int'(a % NBYTES) / n * n;
      for (int i = 0; i < n; i++) mb[base + i] = 8'((d >> (8 * i)) & 32'hFF);
   endtask

   // One access from IDLE; checks stall length, DONE-cycle ReadData and AlignErr
   task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
      int  n = nbytes(sz);
      bit  mis = (a % n) != 0;
      int  exp_stall = mis ? 1 : LATENCY + 1;
      int  st = 0;
      bit  done = 0;
      if (mis) exp_rd = '0;
      else if (wr) begin
         m_store(a, sz, wd);
         if (rd) exp_rd = '0;
         m_stores++;
      end else begin
         exp_rd = m_load(a, sz, uns);
         m_loads++;
      end
      m_stalls += exp_stall;
      MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = a; WriteData = wd;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge Clk);
         if (Stall) st++;
         else done = 1;
      end
      check("done_seen", 32'(done), 32'd1);
      check("stall_len", 32'(st), 32'(exp_stall));
      check("readdata", ReadData, exp_rd);
      check("alignerr", 32'(AlignErr), 32'(mis));
      got = ReadData;
      @(posedge Clk); #1;
      MemRead = 0; MemWrite = 0;
   endtask

   task automatic check_stats(input string tag);
`ifdef MEM_ACCESS_STATS_EN
      check({tag, "_loads"},  LoadCount,   32'(m_loads));
      check({tag, "_stores"}, StoreCount,  32'(m_stores));
      check({tag, "_stalls"}, StallCycles, 32'(m_stalls));
`else
      check({tag, "_loads"},  LoadCount,   32'd0);
      check({tag, "_stores"}, StoreCount,  32'd0);
      check({tag, "_stalls"}, StallCycles, 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] got;
      logic        rd, wr;
      Rst = 1; MemRead = 0; MemWrite = 0; Size = 0; Unsigned = 0; Address = 0; WriteData = 0;
      repeat (3) @(posedge Clk);
      #1 Rst = 0;
      @(negedge Clk);
      check("rst_readdata", ReadData, 32'd0);
      check("rst_alignerr", 32'(AlignErr), 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);
      check_stats("rst");
      @(posedge Clk); #1;

      for (int w = 0; w < 16; w++) do_access(0, 1, 2'b00, 0, 32'(4 * w), $urandom, got);

      do_access(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, got);
      do_access(1, 0, 2'b00, 0, 32'h10, 0, got);
      check("ld_w_10", got, 32'hDEADBEEF);
      do_access(0, 1, 2'b10, 0, 32'h11, 32'h7F, got);
      do_access(1, 0, 2'b00, 0, 32'h10, 0, got);
      check("ld_w_after_sb", got, 32'hDEAD7FEF);
      do_access(1, 0, 2'b10, 0, 32'h13, 0, got);
      check("lb_s_13", got, 32'hFFFFFFDE);
      do_access(1, 0, 2'b10, 1, 32'h13, 0, got);
      check("lb_u_13", got, 32'h000000DE);
      do_access(1, 0, 2'b01, 0, 32'h12, 0, got);
      check("lh_s_12", got, 32'hFFFFDEAD);
      do_access(1, 0, 2'b01, 1, 32'h12, 0, got);
      check("lh_u_12", got, 32'h0000DEAD);
      do_access(0, 1, 2'b01, 0, 32'h12, 32'h1234, got);
      do_access(1, 0, 2'b00, 0, 32'h10, 0, got);
      check("ld_w_after_sh", got, 32'h12347FEF);
      do_access(1, 0, 2'b00, 0, 32'h2, 0, got);
      check("misalign_rd", got, 32'd0);
      do_access(0, 1, 2'b00, 0, 32'h2, 32'hFFFF_FFFF, got);
      do_access(1, 0, 2'b00, 0, 32'h0, 0, got);
      do_access(1, 1, 2'b11, 0, 32'hFFFF_F014, 32'hCAFE_F00D, got);
      check("rdwr_clear", got, 32'd0);

      for (int t = 0; t < 200; t++) begin
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1;
         do_access(rd, wr, 2'($urandom), 1'($urandom),
                   ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom, got);
      end
      check_stats("random");

      // Reset lands on the access edge of a store; memory must keep the old word
      MemWrite = 1; Size = 2'b00; Address = 32'h20; WriteData = 32'h55;
      @(posedge Clk); @(posedge Clk);
      #1 Rst = 1;
      @(posedge Clk);
      #1 Rst = 0; MemWrite = 0;
      exp_rd = '0; m_loads = 0; m_stores = 0; m_stalls = 0;
      @(negedge Clk);
      check("midrst_stall", 32'(Stall), 32'd0);
      check("midrst_readdata", ReadData, 32'd0);
      @(posedge Clk); #1;
      do_access(1, 0, 2'b00, 0, 32'h20, 0, got);

      do_access(1, 0, 2'b00, 0, 32'h24, 0, got);
      do_access(1, 0, 2'b10, 1, 32'h25, 0, got);
      do_access(0, 1, 2'b01, 0, 32'h26, 32'h0BAD, got);
      do_access(0, 1, 2'b10, 0, 32'h27, 32'h99, got);
      check_stats("final");
`ifdef MEM_ACCESS_STATS_EN
      check("final_loads_abs", LoadCount, 32'd3);
      check("final_stores_abs", StoreCount, 32'd2);
      check("final_stalls_abs", StallCycles, 32'd15);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 5-stage pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Performs word, half-word and byte loads and stores on an internal data memory, with a configurable multi-cycle access latency.
- Drives Stall to hold the upstream pipeline registers until the access completes.
- ReadData feeds the MEM/WB register's memory-data input.

Parameters:
- DEPTH, 1024: number of 32-bit words in the data memory; power of two.
- LATENCY, 2: BUSY-state cycles per access; legal range 1..15.

Ports:
- Clk  in  1  clock; all state updates on the posedge.
- Rst  in  1  reset: synchronous, active-high.
- MemRead  in  1  load request from the EX/MEM register.
- MemWrite  in  1  store request from the EX/MEM register.
- Size  in  2  access size: 00 word, 01 half, 10 byte; 11 is treated as word.
- Unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
- Address  in  32  byte address, taken from the ALU result.
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  registered, extended load result.
- Stall  out  1  combinational; 1 holds the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers (their Ld = ~Stall).
- AlignErr  out  1  registered; misaligned-access flag.
- LoadCount  out  32  loads completed.
- StoreCount  out  32  stores completed.
- StallCycles  out  32  cycles with Stall=1.

Behaviour:
- Reset: FSM=IDLE, ReadData=0, AlignErr=0, counter=0, all statistics outputs=0. Memory contents are not reset.
- Rst mid-access: the operation is abandoned and memory is not written.
- Req = MemRead | MemWrite. If both are 1, the access is a store and ReadData is cleared to 0.
- Misaligned: Size=word with Address[1:0]!=0, or Size=half with Address[0]!=0.
- Word index = Address[log2(DEPTH)+1:2]. Upper address bits are ignored (wrap-around).
- Little-endian byte lanes: lane = Address[1:0]; a half-word uses lanes {Address[1],0}+1 : {Address[1],0}.
- FSM IDLE:
  - Stall = Req.
  - Req and aligned: go to BUSY, counter = LATENCY-1.
  - Req and misaligned: go to DONE, AlignErr<=1, ReadData<=0, no memory access.
  - No Req: stay in IDLE, AlignErr<=0.
- FSM BUSY:
  - Stall = 1; counter decrements each cycle.
  - When counter==0 the access is performed at that edge, then go to DONE.
  - Store: only the addressed lanes are written; the other bytes are preserved.
  - Load: the addressed lanes are extracted, extended per Unsigned and registered into ReadData.
- FSM DONE:
  - Stall = 0, so the pipeline registers load at this edge and MEM/WB captures ReadData.
  - Next state is IDLE; AlignErr is cleared on leaving DONE unless re-set.
- Total latency: LATENCY+2 cycles per access from IDLE. A back-to-back request is seen in the IDLE cycle after DONE.
- Inputs must stay stable while Stall=1, which the stalled EX/MEM register guarantees. Changes to the inputs during BUSY are ignored because they are sampled at access time.
- ReadData holds its value until the next completed load, store-with-read clear, alignment error or reset.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined:
  - LoadCount increments at each DONE entry for an aligned load.
  - StoreCount increments at each DONE entry for an aligned store.
  - StallCycles increments every cycle with Stall=1.
  - All three are 32-bit, saturate at 0xFFFFFFFF and are cleared by Rst.
- Undefined: the three ports are constant 0 and no counter logic is built.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word 0x10 (LATENCY=2) -> Stall high for 3 cycles per access; ReadData=0xDEADBEEF in the DONE cycle.
- Store byte 0x7F at 0x11, then load word 0x10 -> 0xDEAD7FEF. Load byte signed 0x13 -> 0xFFFFFFDE. Load byte unsigned 0x13 -> 0x000000DE.
- Load half signed 0x12 -> 0xFFFFDEAD; load half unsigned 0x12 -> 0x0000DEAD; store half 0x1234 at 0x12 then load word 0x10 -> 0x12347FEF.
- Load word at 0x0000_0002 -> no BUSY; AlignErr=1 and ReadData=0 in the next (DONE) cycle; memory unchanged.
- Store word 0x55 to 0x20, asserting Rst during BUSY -> FSM back to IDLE, Stall=0; a subsequent load of 0x20 returns the old value.
- With MEM_ACCESS_STATS_EN: 3 loads + 2 stores at LATENCY=2 -> LoadCount=3, StoreCount=2, StallCycles=15; without the macro all three read 0.
